// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the register-file access sequencer: opcodes,
// instruction field positions and FSM state encoding.
package regfile_seq_pkg;

  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_B = 3'd1,
    S_RD_C = 3'd2,
    S_RD_K = 3'd3,
    S_WR_A = 3'd4,
    S_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/regfile_access_sequencer_opcode_class_decode.sv
// Combinational opcode classifier: which access sequence an opcode needs.
module opcode_class_decode
  import regfile_seq_pkg::*;
(
  input  logic [4:0] op,
  output logic       r_class,
  output logic       i_class,
  output logic       u_class,
  output logic       ba_mode,
  output logic       unsupported
);

  always_comb begin
    r_class = 1'b0;
    i_class = 1'b0;
    u_class = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:    r_class = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: i_class = 1'b1;
      OP_NEG, OP_NOT:                   u_class = 1'b1;
      default: ;
    endcase
  end

  // ldi reads r0 in base-address mode so the immediate is added to zero.
  assign ba_mode     = (op == OP_LDI);
  assign unsupported = ~(r_class | i_class | u_class);

endmodule

// File: rtl/regfile_access_sequencer.sv
// Drives one register-file access per cycle for a captured instruction:
// operand reads onto the A bus, then the ALU-result write-back to ra.
module regfile_access_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
) (
  input  logic              in_clk,
  input  logic              in_clr,
  input  logic [DATA_W-1:0] in_IR,
  input  logic              in_start,
  input  logic              in_flush,
  output logic              out_busy,
  output logic              out_done,
  output logic              out_unsupported,
  output logic [SEL_W-1:0]  out_Aselect,
  output logic              out_read,
  output logic              out_BAout,
  output logic [SEL_W-1:0]  out_Cselect,
  output logic              out_write,
  output logic              out_Yin,
  output logic              out_Zin,
  output logic              out_Cout,
  output logic              out_Zout,
  output logic [2:0]        dbg_state,
  output logic [DATA_W-1:0] dbg_ir
);

  // Handshake: in_start is taken only while out_busy is low (IDLE); every
  // accepted start, flushed or not, ends with exactly one out_done pulse.
  state_t            state, state_next;
  logic [DATA_W-1:0] ir_q;
  logic [4:0]        op_src;
  logic              r_class, i_class, u_class, ba_mode, unsupported;

  // In IDLE the decision is made on the incoming word; afterwards on the copy.
  assign op_src = (state == S_IDLE) ? in_IR[OP_HI:OP_LO] : ir_q[OP_HI:OP_LO];

  opcode_class_decode u_decode (
    .op          (op_src),
    .r_class     (r_class),
    .i_class     (i_class),
    .u_class     (u_class),
    .ba_mode     (ba_mode),
    .unsupported (unsupported)
  );

  always_ff @(posedge in_clk or negedge in_clr) begin
    if (!in_clr) begin
      state <= S_IDLE;
      ir_q  <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && in_start) ir_q <= in_IR;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (in_start) state_next = unsupported ? S_DONE : S_RD_B;
      S_RD_B: begin
        if (in_flush)     state_next = S_DONE;
        else if (r_class) state_next = S_RD_C;
        else if (i_class) state_next = S_RD_K;
        else              state_next = S_WR_A;
      end
      S_RD_C, S_RD_K: state_next = in_flush ? S_DONE : S_WR_A;
      S_WR_A: state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    out_busy        = (state != S_IDLE);
    out_done        = 1'b0;
    out_unsupported = 1'b0;
    out_Aselect     = '0;
    out_read        = 1'b0;
    out_BAout       = 1'b0;
    out_Cselect     = '0;
    out_write       = 1'b0;
    out_Yin         = 1'b0;
    out_Zin         = 1'b0;
    out_Cout        = 1'b0;
    out_Zout        = 1'b0;
    case (state)
      S_RD_B: begin
        out_Aselect = ir_q[RB_HI:RB_LO];
        out_read    = 1'b1;
        out_BAout   = ba_mode;
        // Unary ops have a single operand: it goes straight through the ALU.
        out_Yin     = ~u_class;
        out_Zin     = u_class;
      end
      S_RD_C: begin
        out_Aselect = ir_q[RC_HI:RC_LO];
        out_read    = 1'b1;
        out_Zin     = 1'b1;
      end
      S_RD_K: begin
        out_Cout = 1'b1;
        out_Zin  = 1'b1;
      end
      S_WR_A: begin
        out_Cselect = ir_q[RA_HI:RA_LO];
        out_write   = 1'b1;
        out_Zout    = 1'b1;
      end
      S_DONE: begin
        out_done        = 1'b1;
        out_unsupported = unsupported;
      end
      default: ;
    endcase
  end

  assign dbg_state = state;
  assign dbg_ir    = ir_q;

endmodule
